// File: rtl/hazard_unit.sv
// Pipeline hazard controller: EX forwarding, load-use bubble, branch flush, data-memory wait FSM.
// Latency: stall/flush/forward are combinational from inputs and FSM state; mem_err is registered.
// Backpressure: a busy data memory freezes all stages; optional HAZARD_PERF_EN adds perf counters.
module hazard_unit #(
    parameter int         MEM_TIMEOUT = 16,
    parameter logic [1:0] LOAD_SRC    = 2'b01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic [4:0] rs1_e,
    input  logic [4:0] rs2_e,
    input  logic [4:0] rd_e,
    input  logic       rd_write_e,
    input  logic [1:0] rd_write_src_e,
    input  logic       pc_write_e,
    input  logic [4:0] rd_m,
    input  logic       rd_write_m,
    input  logic       mem_req_m,
    input  logic       mem_ready,
    input  logic [4:0] rd_w,
    input  logic       rd_write_w,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       stall_m,
    output logic       flush_d,
    output logic       flush_e,
    output logic [1:0] forwarding_rs1_e,
    output logic [1:0] forwarding_rs2_e,
    output logic       mem_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        M_IDLE,
        M_WAIT,
        M_ERR
    } mem_state_t;

    mem_state_t        state;
    logic [WCNT_W-1:0] wcnt;
    logic              load_use;
    logic              mem_stall;

    // Memory stage result beats writeback; x0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (rd_write_m && rd_m != 5'd0 && rd_m == rs)
            sel = 2'b10;
        else if (rd_write_w && rd_w != 5'd0 && rd_w == rs)
            sel = 2'b01;
        return sel;
    endfunction

    assign forwarding_rs1_e = fwd_sel(rs1_e);
    assign forwarding_rs2_e = fwd_sel(rs2_e);

    assign load_use = rd_write_e && (rd_write_src_e == LOAD_SRC) && (rd_e != 5'd0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));

    // A ready response in M_WAIT releases the pipe in the same cycle.
    assign mem_stall = (state == M_ERR) ||
                       (!mem_ready && ((state == M_WAIT) || mem_req_m));

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (pc_write_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= M_IDLE;
            wcnt    <= '0;
            mem_err <= 1'b0;
        end else begin
            case (state)
                M_IDLE: begin
                    if (mem_req_m && !mem_ready) begin
                        state <= M_WAIT;
                        wcnt  <= WCNT_W'(1);
                    end else begin
                        wcnt  <= '0;
                    end
                end
                M_WAIT: begin
                    if (mem_ready) begin
                        state <= M_IDLE;
                        wcnt  <= '0;
                    end else if (wcnt == WCNT_MAX) begin
                        state   <= M_ERR;
                        mem_err <= 1'b1;
                    end else begin
                        wcnt <= wcnt + WCNT_W'(1);
                    end
                end
                M_ERR: begin
                    state <= M_ERR;
                end
                default: begin
                    state <= M_IDLE;
                    wcnt  <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_d && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush_e && perf_flush_cnt != 32'hFFFF_FFFF)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios then randomized cycles against a reference model.
module tb_hazard_unit;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       rd_write_e, pc_write_e, rd_write_m, mem_req_m, mem_ready, rd_write_w;
    logic [1:0] rd_write_src_e;
    logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_err;
    logic [1:0] forwarding_rs1_e, forwarding_rs2_e;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model: consecutive stalled memory cycles, sticky error, perf tallies.
    int  waited = 0;
    bit  merr = 1'b0;
    int  pstall = 0;
    int  pflush = 0;
    bit  exp_ms, exp_stall_d, exp_flush_e;

    always #5 clk = ~clk;

    hazard_unit #(.MEM_TIMEOUT(TO), .LOAD_SRC(2'b01)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_write_e(rd_write_e), .rd_write_src_e(rd_write_src_e),
        .pc_write_e(pc_write_e), .rd_m(rd_m), .rd_write_m(rd_write_m),
        .mem_req_m(mem_req_m), .mem_ready(mem_ready), .rd_w(rd_w), .rd_write_w(rd_write_w),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e),
        .forwarding_rs1_e(forwarding_rs1_e), .forwarding_rs2_e(forwarding_rs2_e),
        .mem_err(mem_err)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        if (rd_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (rd_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check_all(input string tag);
        bit lu;
        logic [5:0] ctl;
        lu = rd_write_e && rd_write_src_e == 2'b01 && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
        exp_ms = merr || (!mem_ready && (waited > 0 || mem_req_m));
        // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}
        if (exp_ms)          ctl = 6'b111100;
        else if (pc_write_e) ctl = 6'b000011;
        else if (lu)         ctl = 6'b110001;
        else                 ctl = 6'b000000;
        exp_stall_d = ctl[4];
        exp_flush_e = ctl[0];
        chk({tag, ".ctl"}, 32'({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}), 32'(ctl));
        chk({tag, ".fwd1"}, 32'(forwarding_rs1_e), 32'(model_fwd(rs1_e)));
        chk({tag, ".fwd2"}, 32'(forwarding_rs2_e), 32'(model_fwd(rs2_e)));
        chk({tag, ".mem_err"}, 32'(mem_err), 32'(merr));
`ifdef HAZARD_PERF_EN
        chk({tag, ".perf_stall"}, perf_stall_cnt, 32'(pstall));
        chk({tag, ".perf_flush"}, perf_flush_cnt, 32'(pflush));
`endif
    endtask

    task automatic model_update();
        if (rst) begin
            waited = 0;
            merr   = 1'b0;
            pstall = 0;
            pflush = 0;
        end else begin
            pstall += int'(exp_stall_d);
            pflush += int'(exp_flush_e);
            if (!merr) begin
                if (exp_ms) begin
                    waited++;
                    if (waited > TO) merr = 1'b1;
                end else begin
                    waited = 0;
                end
            end
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
        {rd_write_e, pc_write_e, rd_write_m, rd_write_w, mem_req_m} = '0;
        rd_write_src_e = 2'b00;
        mem_ready = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        model_update();
        #1;
        step("reset");
        rst = 1'b0;
        step("idle");

        // M-stage forward beats W-stage forward
        rd_write_m = 1; rd_m = 5; rd_write_w = 1; rd_w = 5; rs1_e = 5;
        step("fwd_m_over_w");
        chk("fwd_m_literal", 32'(forwarding_rs1_e), 32'd2);
        rd_write_m = 0;
        step("fwd_w_only");

        // x0 never forwarded
        rd_write_m = 1; rd_m = 0; rd_w = 0; rs2_e = 0; rs1_e = 0;
        step("fwd_x0");
        chk("fwd_x0_literal", 32'(forwarding_rs2_e), 32'd0);
        idle_inputs();

        // Load-use: one bubble, then clear
        rd_write_e = 1; rd_e = 7; rd_write_src_e = 2'b01; rs2_d = 7;
        step("load_use");
        chk("load_use_literal", 32'({stall_f, stall_d, flush_e}), 32'b111);
        rd_write_e = 0;
        step("load_use_after");

        // Branch beats load-use
        rd_write_e = 1; pc_write_e = 1;
        step("branch_over_lu");
        idle_inputs();

        // Memory wait 3 cycles with pending branch, then release
        mem_req_m = 1; mem_ready = 0; pc_write_e = 1;
        for (int i = 0; i < 3; i++) step("mem_wait");
        mem_ready = 1;
        step("mem_release");
        chk("release_flush", 32'({flush_d, flush_e}), 32'b11);
        idle_inputs();
        step("post_release");

        // Timeout: error becomes sticky, then reset clears it
        mem_req_m = 1; mem_ready = 0;
        for (int i = 0; i < TO + 2; i++) step("timeout");
        chk("timeout_err_literal", 32'(mem_err), 32'd1);
        mem_ready = 1; mem_req_m = 0;
        step("err_sticky");
        rst = 1;
        step("err_reset");
        rst = 0;
        step("after_reset");
        chk("after_reset_err_literal", 32'(mem_err), 32'd0);

        // Randomized traffic with small register numbers to force collisions
        for (int n = 0; n < 400; n++) begin
            rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
            rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
            rd_w  = 5'($urandom_range(0, 3));
            rd_write_e = 1'($urandom); rd_write_m = 1'($urandom); rd_write_w = 1'($urandom);
            rd_write_src_e = 2'($urandom);
            pc_write_e = ($urandom_range(0, 5) == 0);
            mem_req_m  = ($urandom_range(0, 2) == 0);
            mem_ready  = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 39) == 0);
            step("rand");
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
